// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin, lockable arbiter sharing one memory port between two requesters
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   mN_rd/mN_wr/mN_lock       read/write beat request and grant hold from requester N (N=0,1)
//   mN_addr/mN_wdata          beat address and write data from requester N
//   mN_busy                   beat not accepted this cycle, requester holds its request
//   mN_rdata/mN_rvalid        read data (broadcast) and per-owner valid pulse
//   mem_rd/mem_wr/mem_addr/mem_wdata/mem_rdata/mem_busy   shared memory port
// Optional: define ARB_STATS_EN to add grant_cnt0/1 and wait_cnt0/1 statistics outputs.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_rd,
    input  logic              m0_wr,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_busy,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_rd,
    input  logic              m1_wr,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_busy,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       grant_cnt0,
    output logic [31:0]       grant_cnt1,
    output logic [31:0]       wait_cnt0,
    output logic [31:0]       wait_cnt1
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;
    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [RD_LAT-1:0] pv_q, pv_d, pid_q, pid_d;
    logic              req0, req1, gnt0, gnt1, req_x, req_o, lock_x, acc, last, rel_a, rel;

    assign req0   = m0_rd | m0_wr;
    assign req1   = m1_rd | m1_wr;
    assign gnt0   = state_q == GNT0;
    assign gnt1   = state_q == GNT1;
    assign req_x  = gnt1 ? req1 : req0;
    assign req_o  = gnt1 ? req0 : req1;
    assign lock_x = gnt1 ? m1_lock : m0_lock;
    assign acc    = (mem_rd | mem_wr) & ~mem_busy;
    assign last   = acc & ((32'(cnt_q) + 32'd1) == 32'(LOCK_MAX));
    assign rel_a  = acc & ~lock_x;
    // Release: unlocked accepted beat, unlocked idle requester, or lock budget exhausted
    assign rel    = (gnt0 | gnt1) & (rel_a | (~req_x & ~lock_x) | last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            pv_q    <= '0;
            pid_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            pv_q    <= pv_d;
            pid_q   <= pid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rel ? gnt0 : rr_q;
        cnt_d   = rel ? 8'd0 : acc ? cnt_q + 8'd1 : cnt_q;
        // Tag pipe: valid bit and owner id shift every cycle, head is the oldest read
        pv_d    = (pv_q << 1) | RD_LAT'(acc & mem_rd);
        pid_d   = (pid_q << 1) | RD_LAT'(gnt1);
        if (!(gnt0 | gnt1))
            state_d = (req0 & req1) ? (rr_q ? GNT1 : GNT0) : req0 ? GNT0 : req1 ? GNT1 : IDLE;
        else if (rel)
            state_d = req_o ? (gnt0 ? GNT1 : GNT0) : (req_x & rel_a) ? state_q : IDLE;
    end

    always_comb begin
        mem_wr    = gnt0 ? m0_wr : gnt1 ? m1_wr : 1'b0;
        mem_rd    = gnt0 ? (m0_rd & ~m0_wr) : gnt1 ? (m1_rd & ~m1_wr) : 1'b0;
        mem_addr  = gnt0 ? m0_addr : gnt1 ? m1_addr : '0;
        mem_wdata = gnt0 ? m0_wdata : gnt1 ? m1_wdata : '0;
        m0_busy   = gnt0 ? mem_busy : req0;
        m1_busy   = gnt1 ? mem_busy : req1;
        m0_rvalid = pv_q[RD_LAT-1] & ~pid_q[RD_LAT-1];
        m1_rvalid = pv_q[RD_LAT-1] & pid_q[RD_LAT-1];
        m0_rdata  = pv_q[RD_LAT-1] ? mem_rdata : '0;
        m1_rdata  = m0_rdata;
    end

`ifdef ARB_STATS_EN
    logic [31:0] gc0_q, gc1_q, wc0_q, wc1_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gc0_q <= '0;
            gc1_q <= '0;
            wc0_q <= '0;
            wc1_q <= '0;
        end else begin
            if (state_d == GNT0 && (!gnt0 || rel)) gc0_q <= gc0_q + 32'd1;
            if (state_d == GNT1 && (!gnt1 || rel)) gc1_q <= gc1_q + 32'd1;
            if (m0_busy & req0) wc0_q <= wc0_q + 32'd1;
            if (m1_busy & req1) wc1_q <= wc1_q + 32'd1;
        end
    end
    assign grant_cnt0 = gc0_q;
    assign grant_cnt1 = gc1_q;
    assign wait_cnt0  = wc0_q;
    assign wait_cnt1  = wc1_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with directed vectors
module tb_mem_port_arbiter;
    localparam logic [31:0] K = 32'hA5A5_0000;
    logic        clk = 1'b0, rst;
    logic        m0_rd, m0_wr, m0_lock, m1_rd, m1_wr, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_busy, m1_busy, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_rd, mem_wr, mem_busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .LOCK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_busy(m0_busy), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_busy(m1_busy), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy)
    );

    typedef struct packed {
        logic        id;
        logic        rd;
        logic        wr;
        logic        lock;
        logic        b2b;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;
    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } rret_t;

    beat_t q0[$], q1[$], eq[$];
    rret_t rq[$];
    beat_t me;
    rret_t mr;
    int    n_chk = 0, n_fail = 0, cyc = 0, last_acc = -10;
    logic  a0, a1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic beat_t bt(logic id, logic rd, logic wr, logic lock, logic [31:0] addr, logic [31:0] wdata);
        beat_t b;
        b.id = id; b.rd = rd; b.wr = wr; b.lock = lock; b.b2b = 1'b0; b.addr = addr; b.wdata = wdata;
        return b;
    endfunction

    task automatic issue(beat_t b);
        if (b.id) q1.push_back(b); else q0.push_back(b);
    endtask

    task automatic expect_beat(beat_t b, logic b2b);
        b.b2b = b2b;
        eq.push_back(b);
        if (b.rd) rq.push_back({b.id, b.addr ^ K});
    endtask

    // Memory model: read data appears one cycle after an accepted read
    always @(posedge clk) if (mem_rd && !mem_busy) mem_rdata <= mem_addr ^ K;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester drivers: present the queue head, advance once the beat was accepted
    initial begin
        {m0_rd, m0_wr, m0_lock, m0_addr, m0_wdata} = '0;
        {m1_rd, m1_wr, m1_lock, m1_addr, m1_wdata} = '0;
        forever begin
            @(negedge clk);
            a0 = (m0_rd || m0_wr) && !m0_busy && !rst;
            a1 = (m1_rd || m1_wr) && !m1_busy && !rst;
            @(posedge clk);
            #1;
            if (a0 && q0.size() > 0) void'(q0.pop_front());
            if (a1 && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) {m0_rd, m0_wr, m0_lock, m0_addr, m0_wdata} = {q0[0].rd, q0[0].wr, q0[0].lock, q0[0].addr, q0[0].wdata};
            else {m0_rd, m0_wr, m0_lock, m0_addr, m0_wdata} = '0;
            if (q1.size() > 0) {m1_rd, m1_wr, m1_lock, m1_addr, m1_wdata} = {q1[0].rd, q1[0].wr, q1[0].lock, q1[0].addr, q1[0].wdata};
            else {m1_rd, m1_wr, m1_lock, m1_addr, m1_wdata} = '0;
        end
    end

    // Monitor: compares every accepted memory beat and every read return against the queues
    always @(negedge clk) begin
        if (!rst && (mem_rd || mem_wr) && !mem_busy) begin
            if (eq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL beat_unexpected: got addr %h with no beat expected", mem_addr);
            end else begin
                me = eq.pop_front();
                check("beat_wr", 32'(mem_wr), 32'(me.wr));
                check("beat_rd", 32'(mem_rd), 32'(me.rd));
                check("beat_addr", mem_addr, me.addr);
                if (me.wr) check("beat_wdata", mem_wdata, me.wdata);
                if (me.b2b) check("beat_b2b_cycle", cyc, last_acc + 1);
            end
            last_acc = cyc;
        end
        if (m0_rvalid || m1_rvalid) begin
            check("rvalid_onehot", 32'(m0_rvalid & m1_rvalid), 32'd0);
            if (rq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rvalid_unexpected: got rvalid %b%b with no read outstanding", m1_rvalid, m0_rvalid);
            end else begin
                mr = rq.pop_front();
                check("rvalid_owner", 32'(m1_rvalid), 32'(mr.id));
                check("rdata_m0", m0_rdata, mr.data);
                check("rdata_m1", m1_rdata, mr.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1;
        mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_mem_wr", 32'(mem_wr), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", {m1_busy, m0_busy}, 0);
        check("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
        check("rst_rdata0", m0_rdata, 0);
        check("rst_rdata1", m1_rdata, 0);
        rst = 1'b0;

        // Single read from reset: one arbitration cycle, beat, then return
        @(negedge clk);
        issue(bt(0, 1, 0, 0, 32'h40, 0));
        expect_beat(bt(0, 1, 0, 0, 32'h40, 0), 0);
        @(negedge clk);
        check("t1_arb_mem_rd", 32'(mem_rd), 0);
        check("t1_arb_busy", 32'(m0_busy), 1);
        @(negedge clk);
        check("t1_beat_mem_rd", 32'(mem_rd), 1);
        check("t1_beat_addr", mem_addr, 32'h40);
        check("t1_beat_busy", 32'(m0_busy), 0);
        @(negedge clk);
        check("t1_rvalid0", 32'(m0_rvalid), 1);
        check("t1_rvalid1", 32'(m1_rvalid), 0);
        check("t1_rdata", m0_rdata, 32'h40 ^ K);
        repeat (6) @(negedge clk);

        // Simultaneous writes from reset: m0 first, m1 with no bubble
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(bt(0, 0, 1, 0, 32'h100, 32'h1111_0000));
        issue(bt(1, 0, 1, 0, 32'h180, 32'h2222_0000));
        expect_beat(bt(0, 0, 1, 0, 32'h100, 32'h1111_0000), 0);
        expect_beat(bt(1, 0, 1, 0, 32'h180, 32'h2222_0000), 1);
        repeat (8) @(negedge clk);

        // Lock burst: four locked m1 reads while m0 waits
        for (int i = 0; i < 4; i++) begin
            issue(bt(1, 1, 0, i < 3, 32'h200 + 32'(4 * i), 0));
            expect_beat(bt(1, 1, 0, 0, 32'h200 + 32'(4 * i), 0), i > 0);
        end
        @(negedge clk);
        issue(bt(0, 0, 1, 0, 32'h300, 32'h3333_0000));
        expect_beat(bt(0, 0, 1, 0, 32'h300, 32'h3333_0000), 1);
        w = 0;
        repeat (8) begin
            @(negedge clk);
            if (m0_wr && m0_busy) w++;
        end
        check("t3_m0_wait_cycles", w, 4);
        repeat (4) @(negedge clk);

        // Forced release after LOCK_MAX=4 beats of a locked 8-beat m0 burst
        for (int i = 0; i < 8; i++) issue(bt(0, 0, 1, i < 7, 32'h400 + 32'(4 * i), 32'h4000 + 32'(i)));
        for (int i = 0; i < 4; i++) expect_beat(bt(0, 0, 1, 0, 32'h400 + 32'(4 * i), 32'h4000 + 32'(i)), i > 0);
        expect_beat(bt(1, 0, 1, 0, 32'h480, 32'h5555_0000), 1);
        for (int i = 4; i < 8; i++) expect_beat(bt(0, 0, 1, 0, 32'h400 + 32'(4 * i), 32'h4000 + 32'(i)), 1);
        @(negedge clk);
        issue(bt(1, 0, 1, 0, 32'h480, 32'h5555_0000));
        repeat (16) @(negedge clk);

        // Memory stall for three cycles between two locked m0 reads
        issue(bt(0, 1, 0, 1, 32'h500, 0));
        issue(bt(0, 1, 0, 0, 32'h504, 0));
        expect_beat(bt(0, 1, 0, 0, 32'h500, 0), 0);
        expect_beat(bt(0, 1, 0, 0, 32'h504, 0), 0);
        repeat (3) @(posedge clk);
        #1 mem_busy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t5_stall_busy", 32'(m0_busy), 1);
            check("t5_stall_addr", mem_addr, 32'h504);
        end
        @(posedge clk);
        #1 mem_busy = 1'b0;
        @(negedge clk);
        check("t5_resume_busy", 32'(m0_busy), 0);
        check("t5_resume_rd", 32'(mem_rd), 1);
        repeat (6) @(negedge clk);

        // Reset with a read in flight: return is dropped, outputs clear at once
        issue(bt(0, 1, 0, 0, 32'h600, 0));
        eq.push_back(bt(0, 1, 0, 0, 32'h600, 0));
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rvalid", {m1_rvalid, m0_rvalid}, 0);
        check("t6_mem_rd", 32'(mem_rd), 0);
        check("t6_mem_addr", mem_addr, 0);
        check("t6_rdata", m0_rdata, 0);
        check("t6_busy", {m1_busy, m0_busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 50 && (eq.size() > 0 || rq.size() > 0); i++) @(negedge clk);
        check("end_beats_pending", eq.size(), 0);
        check("end_reads_pending", rq.size(), 0);
        check("end_stim_pending", q0.size() + q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
